pipeline_hazard_ctrl: RTL and testbench

- Central sequencer for the pipeline latch enables and flushes: PC, F/D, D/X and X/M latches.
- Detects load-use hazards and taken branches, and freezes the front of the pipeline while the multi-cycle mult/div unit runs.
- Drives the latch in_enable inputs and the nop-injection (flush) selects.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline latch enable/flush sequencer with load-use,
// branch and mult/div stall handling plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int MD_TIMEOUT = 40,
    parameter int CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       d_rs,
    input  logic [4:0]       d_rt,
    input  logic             d_uses_rs,
    input  logic             d_uses_rt,
    input  logic             x_is_load,
    input  logic [4:0]       x_rd,
    input  logic             x_branch_taken,
    input  logic             x_is_md,
    input  logic             md_ready,
    output logic             pc_we,
    output logic             fd_we,
    output logic             fd_flush,
    output logic             dx_we,
    output logic             dx_flush,
    output logic             xm_we,
    output logic             xm_flush,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WC_W = $clog2(MD_TIMEOUT + 1);

    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [WC_W-1:0] wait_cnt;
    logic [WC_W-1:0] wait_cnt_next;
    logic            hz;
    logic            md_expire;

    assign hz = x_is_load && (x_rd != 5'd0) &&
                ((d_uses_rs && (d_rs == x_rd)) || (d_uses_rt && (d_rt == x_rd)));

    assign md_expire = (wait_cnt == WC_W'(MD_TIMEOUT - 1));

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        pc_we         = 1'b1;
        fd_we         = 1'b1;
        dx_we         = 1'b1;
        xm_we         = 1'b1;
        fd_flush      = 1'b0;
        dx_flush      = 1'b0;
        xm_flush      = 1'b0;
        md_start      = 1'b0;
        md_busy       = 1'b0;

        if (reset) begin
            // Clock nops into every latch while reset is held.
            fd_flush = 1'b1;
            dx_flush = 1'b1;
            xm_flush = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (x_is_md) begin
                        md_start      = 1'b1;
                        state_next    = MD_WAIT;
                        wait_cnt_next = '0;
                        pc_we         = 1'b0;
                        fd_we         = 1'b0;
                        dx_we         = 1'b0;
                        xm_flush      = 1'b1;
                    end else if (x_branch_taken) begin
                        // The D instruction is squashed, so a pending hazard is moot.
                        fd_flush = 1'b1;
                        dx_flush = 1'b1;
                    end else if (hz) begin
                        pc_we    = 1'b0;
                        fd_we    = 1'b0;
                        dx_flush = 1'b1;
                    end
                end
                MD_WAIT: begin
                    md_busy       = 1'b1;
                    wait_cnt_next = wait_cnt + WC_W'(1);
                    if (md_ready || md_expire) begin
                        state_next = RUN;
                    end else begin
                        pc_we    = 1'b0;
                        fd_we    = 1'b0;
                        dx_we    = 1'b0;
                        xm_flush = 1'b1;
                    end
                end
                default: begin
                    state_next = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            md_timeout  <= 1'b0;
            stall_count <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if ((state == MD_WAIT) && !md_ready && md_expire) begin
                md_timeout <= 1'b1;
            end
            if (!pc_we && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

    logic        clock;
    logic        reset;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic        d_uses_rs;
    logic        d_uses_rt;
    logic        x_is_load;
    logic [4:0]  x_rd;
    logic        x_branch_taken;
    logic        x_is_md;
    logic        md_ready;

    logic        pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, xm_flush;
    logic        md_start, md_busy, md_timeout;
    logic [31:0] stall_count;

    logic        s_pc_we, s_fd_we, s_fd_flush, s_dx_we, s_dx_flush, s_xm_we, s_xm_flush;
    logic        s_md_start, s_md_busy, s_md_timeout;
    logic [3:0]  s_stall_count;

    int total = 0;
    int bad   = 0;

    // {pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, xm_flush, md_start, md_busy}
    logic [8:0] ctl;
    assign ctl = {pc_we, fd_we, fd_flush, dx_we, dx_flush, xm_we, xm_flush, md_start, md_busy};

    localparam logic [8:0] C_RST   = 9'b111111100;
    localparam logic [8:0] C_NORM  = 9'b110101000;
    localparam logic [8:0] C_HZ    = 9'b000111000;
    localparam logic [8:0] C_BR    = 9'b111111000;
    localparam logic [8:0] C_START = 9'b000001110;
    localparam logic [8:0] C_WAIT  = 9'b000001101;
    localparam logic [8:0] C_EXIT  = 9'b110101001;

    pipeline_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(32)) dut (
        .clock(clock), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
        .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .x_is_load(x_is_load),
        .x_rd(x_rd), .x_branch_taken(x_branch_taken), .x_is_md(x_is_md),
        .md_ready(md_ready), .pc_we(pc_we), .fd_we(fd_we), .fd_flush(fd_flush),
        .dx_we(dx_we), .dx_flush(dx_flush), .xm_we(xm_we), .xm_flush(xm_flush),
        .md_start(md_start), .md_busy(md_busy), .md_timeout(md_timeout),
        .stall_count(stall_count)
    );

    pipeline_hazard_ctrl #(.MD_TIMEOUT(40), .CNT_W(4)) dut_small (
        .clock(clock), .reset(reset), .d_rs(d_rs), .d_rt(d_rt),
        .d_uses_rs(d_uses_rs), .d_uses_rt(d_uses_rt), .x_is_load(x_is_load),
        .x_rd(x_rd), .x_branch_taken(x_branch_taken), .x_is_md(x_is_md),
        .md_ready(md_ready), .pc_we(s_pc_we), .fd_we(s_fd_we), .fd_flush(s_fd_flush),
        .dx_we(s_dx_we), .dx_flush(s_dx_flush), .xm_we(s_xm_we), .xm_flush(s_xm_flush),
        .md_start(s_md_start), .md_busy(s_md_busy), .md_timeout(s_md_timeout),
        .stall_count(s_stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic clear_inputs();
        d_rs = 5'd0; d_rt = 5'd0; d_uses_rs = 1'b0; d_uses_rt = 1'b0;
        x_is_load = 1'b0; x_rd = 5'd0; x_branch_taken = 1'b0;
        x_is_md = 1'b0; md_ready = 1'b0;
    endtask

    task automatic set_rt_hazard(input logic [4:0] rd);
        x_is_load = 1'b1; x_rd = rd; d_uses_rt = 1'b1; d_rt = rd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock); #1;
            total++;
            if (ctl !== C_RST) begin
                bad++; $display("FAIL reset_ctl cycle=%0d got=%b exp=%b", i, ctl, C_RST);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (ctl !== C_NORM) begin
            bad++; $display("FAIL post_reset_ctl got=%b exp=%b", ctl, C_NORM);
        end
        total++;
        if (stall_count !== 32'd0) begin
            bad++; $display("FAIL post_reset_stall got=%0d exp=0", stall_count);
        end
        total++;
        if (md_timeout !== 1'b0) begin
            bad++; $display("FAIL post_reset_timeout got=%b exp=0", md_timeout);
        end
    endtask

    task automatic test_load_use();
        @(negedge clock);
        set_rt_hazard(5'd5);
        #1;
        total++;
        if (ctl !== C_HZ) begin
            bad++; $display("FAIL hz_rt_ctl got=%b exp=%b", ctl, C_HZ);
        end
        @(negedge clock);
        clear_inputs();
        x_is_load = 1'b1; x_rd = 5'd0; d_uses_rt = 1'b1; d_rt = 5'd0;
        #1;
        total++;
        if (stall_count !== 32'd1) begin
            bad++; $display("FAIL hz_rt_stall got=%0d exp=1", stall_count);
        end
        total++;
        if (ctl !== C_NORM) begin
            bad++; $display("FAIL hz_rd0_ctl got=%b exp=%b", ctl, C_NORM);
        end
        @(negedge clock);
        clear_inputs();
        x_is_load = 1'b1; x_rd = 5'd9; d_rs = 5'd9; d_uses_rs = 1'b0;
        #1;
        total++;
        if (ctl !== C_NORM) begin
            bad++; $display("FAIL hz_unused_rs_ctl got=%b exp=%b", ctl, C_NORM);
        end
        @(negedge clock);
        d_uses_rs = 1'b1;
        #1;
        total++;
        if (ctl !== C_HZ) begin
            bad++; $display("FAIL hz_rs_ctl got=%b exp=%b", ctl, C_HZ);
        end
        @(negedge clock);
        clear_inputs();
        #1;
        total++;
        if (stall_count !== 32'd2) begin
            bad++; $display("FAIL hz_rs_stall got=%0d exp=2", stall_count);
        end
    endtask

    task automatic test_branch();
        @(negedge clock);
        set_rt_hazard(5'd5);
        x_branch_taken = 1'b1;
        #1;
        total++;
        if (ctl !== C_BR) begin
            bad++; $display("FAIL branch_ctl got=%b exp=%b", ctl, C_BR);
        end
        @(negedge clock);
        clear_inputs();
        md_ready = 1'b1;
        #1;
        total++;
        if (stall_count !== 32'd2) begin
            bad++; $display("FAIL branch_stall got=%0d exp=2", stall_count);
        end
        total++;
        if (ctl !== C_NORM) begin
            bad++; $display("FAIL ready_in_run_ctl got=%b exp=%b", ctl, C_NORM);
        end
    endtask

    task automatic test_md();
        @(negedge clock);
        clear_inputs();
        x_is_md = 1'b1;
        #1;
        total++;
        if (ctl !== C_START) begin
            bad++; $display("FAIL md_start_ctl got=%b exp=%b", ctl, C_START);
        end
        for (int i = 1; i <= 5; i++) begin
            @(negedge clock);
            md_ready = (i == 5);
            #1;
            total++;
            if (ctl !== ((i == 5) ? C_EXIT : C_WAIT)) begin
                bad++; $display("FAIL md_wait_ctl cycle=%0d got=%b exp=%b", i, ctl,
                                (i == 5) ? C_EXIT : C_WAIT);
            end
        end
        @(negedge clock);
        clear_inputs();
        #1;
        total++;
        if (ctl !== C_NORM) begin
            bad++; $display("FAIL md_after_ctl got=%b exp=%b", ctl, C_NORM);
        end
        total++;
        if (stall_count !== 32'd7) begin
            bad++; $display("FAIL md_stall got=%0d exp=7", stall_count);
        end
        total++;
        if (md_timeout !== 1'b0) begin
            bad++; $display("FAIL md_no_timeout got=%b exp=0", md_timeout);
        end
    endtask

    task automatic test_timeout();
        @(negedge clock);
        x_is_md = 1'b1;
        #1;
        total++;
        if (ctl !== C_START) begin
            bad++; $display("FAIL to_start_ctl got=%b exp=%b", ctl, C_START);
        end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock); #1;
            total++;
            if (ctl !== ((i == 40) ? C_EXIT : C_WAIT)) begin
                bad++; $display("FAIL to_wait_ctl cycle=%0d got=%b exp=%b", i, ctl,
                                (i == 40) ? C_EXIT : C_WAIT);
            end
            total++;
            if (md_timeout !== 1'b0) begin
                bad++; $display("FAIL to_early cycle=%0d got=%b exp=0", i, md_timeout);
            end
        end
        @(negedge clock);
        clear_inputs();
        #1;
        total++;
        if (ctl !== C_NORM || md_timeout !== 1'b1) begin
            bad++; $display("FAIL to_exit got ctl=%b to=%b exp ctl=%b to=1", ctl, md_timeout, C_NORM);
        end
        total++;
        if (stall_count !== 32'd47) begin
            bad++; $display("FAIL to_stall got=%0d exp=47", stall_count);
        end
        repeat (3) @(negedge clock);
        #1;
        total++;
        if (md_timeout !== 1'b1) begin
            bad++; $display("FAIL to_sticky got=%b exp=1", md_timeout);
        end
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clock);
        x_is_md = 1'b1;
        @(negedge clock);
        x_is_md = 1'b0;
        #1;
        total++;
        if (ctl !== C_WAIT) begin
            bad++; $display("FAIL rmw_wait_ctl got=%b exp=%b", ctl, C_WAIT);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        total++;
        if (ctl !== C_RST) begin
            bad++; $display("FAIL rmw_reset_ctl got=%b exp=%b", ctl, C_RST);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        total++;
        if (ctl !== C_NORM) begin
            bad++; $display("FAIL rmw_run_ctl got=%b exp=%b", ctl, C_NORM);
        end
        total++;
        if (md_timeout !== 1'b0 || stall_count !== 32'd0) begin
            bad++; $display("FAIL rmw_regs got to=%b stall=%0d exp to=0 stall=0",
                            md_timeout, stall_count);
        end
    endtask

    task automatic test_saturate();
        @(negedge clock);
        set_rt_hazard(5'd12);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock); #1;
            total++;
            if (s_stall_count !== ((k > 15) ? 4'd15 : 4'(k))) begin
                bad++; $display("FAIL sat_count k=%0d got=%0d exp=%0d", k, s_stall_count,
                                (k > 15) ? 15 : k);
            end
        end
        clear_inputs();
        @(negedge clock); #1;
        total++;
        if (s_stall_count !== 4'd15 || stall_count !== 32'd20) begin
            bad++; $display("FAIL sat_hold got small=%0d big=%0d exp small=15 big=20",
                            s_stall_count, stall_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_branch();
        test_md();
        test_timeout();
        test_reset_mid_wait();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
